// File: rtl/multdiv_pkg.sv
// Shared processor constants for the iterative multiply/divide unit:
// operand width, iteration count, counter width and FSM state encoding.
package multdiv_pkg;

    localparam int MD_WIDTH = 32;
    localparam int MD_ITER  = 32;
    localparam int MD_CNT_W = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_e;

    // Two's-complement magnitude; the most negative value maps to itself
    // and is correct when the result is read as unsigned.
    function automatic logic [MD_WIDTH-1:0] mag(input logic [MD_WIDTH-1:0] v);
        return v[MD_WIDTH-1] ? (~v + 1'b1) : v;
    endfunction

endpackage

// File: rtl/multdiv_counter.sv
// Iteration counter: 6-bit up-counter with synchronous clear and a
// terminal-count flag that is high while the count equals ITER-1.
module multdiv_counter
    import multdiv_pkg::*;
#(
    parameter int ITER = MD_ITER
) (
    input  logic clock,
    input  logic reset,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    localparam logic [MD_CNT_W-1:0] TC_VAL = MD_CNT_W'(ITER - 1);

    logic [MD_CNT_W-1:0] count_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else if (clr_i) begin
            count_q <= '0;
        end else if (en_i) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign tc_o = (count_q == TC_VAL);

endmodule

// File: rtl/multdiv.sv
// Iterative signed multiply (radix-2 Booth) and divide (restoring) unit,
// one step per clock, with a registered one-cycle completion strobe.
module multdiv
    import multdiv_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH,
    parameter int ITER  = MD_ITER
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);

    localparam int PW = 2 * WIDTH + 1;

    state_e           state_q, state_d;
    logic [PW-1:0]    work_q, work_d;
    logic [WIDTH-1:0] opnd_q, opnd_d;
    logic             neg_q, neg_d;
    logic             ovf_q, ovf_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             exc_q, exc_d;
    logic             rdy_q, rdy_d;
    logic             busy_q, busy_d;

    logic             start;
    logic             cnt_clr, cnt_en, cnt_tc;

    logic [WIDTH:0]   booth_hi, booth_sum;
    logic [PW-1:0]    booth_next;
    logic [WIDTH:0]   rem_shift, rem_diff;
    logic [PW-1:0]    div_next;
    logic [WIDTH-1:0] quo;

    assign start = ctrl_MULT | ctrl_DIV;

    multdiv_counter #(.ITER(ITER)) u_counter (
        .clock (clock),
        .reset (reset),
        .clr_i (cnt_clr),
        .en_i  (cnt_en),
        .tc_o  (cnt_tc)
    );

    // Booth: work = {hi[W-1:0], multiplier, q-1}; the add is one bit wider so
    // the shifted-in sign stays correct when the multiplicand is the most negative value.
    always_comb begin
        booth_hi = {work_q[PW-1], work_q[PW-1 -: WIDTH]};
        case (work_q[1:0])
            2'b01:   booth_sum = booth_hi + {opnd_q[WIDTH-1], opnd_q};
            2'b10:   booth_sum = booth_hi - {opnd_q[WIDTH-1], opnd_q};
            default: booth_sum = booth_hi;
        endcase
        booth_next = {booth_sum, work_q[WIDTH:1]};
    end

    // Restoring division: work = {remainder[W:0], quotient/dividend[W-1:0]}.
    always_comb begin
        rem_shift = {work_q[PW-2:WIDTH], work_q[WIDTH-1]};
        rem_diff  = rem_shift - {1'b0, opnd_q};
        if (rem_diff[WIDTH]) begin
            div_next = {rem_shift, work_q[WIDTH-2:0], 1'b0};
        end else begin
            div_next = {rem_diff, work_q[WIDTH-2:0], 1'b1};
        end
        quo = div_next[WIDTH-1:0];
    end

    always_comb begin
        state_d  = state_q;
        work_d   = work_q;
        opnd_d   = opnd_q;
        neg_d    = neg_q;
        ovf_d    = ovf_q;
        result_d = result_q;
        exc_d    = exc_q;
        rdy_d    = 1'b0;
        cnt_clr  = 1'b1;
        cnt_en   = 1'b0;

        if (start) begin
            opnd_d  = ctrl_MULT ? data_operandA : mag(data_operandB);
            work_d  = ctrl_MULT ? {{WIDTH{1'b0}}, data_operandB, 1'b0}
                                : {{(WIDTH+1){1'b0}}, mag(data_operandA)};
            neg_d   = data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
            ovf_d   = !ctrl_MULT && (data_operandA == {1'b1, {(WIDTH-1){1'b0}}})
                                 && (data_operandB == {WIDTH{1'b1}});
            state_d = ctrl_MULT ? MUL : DIV;
        end else begin
            case (state_q)
                MUL: begin
                    cnt_clr = 1'b0;
                    cnt_en  = 1'b1;
                    work_d  = booth_next;
                    if (cnt_tc) begin
                        result_d = booth_next[WIDTH:1];
                        exc_d    = booth_next[PW-1:WIDTH+1] != {WIDTH{booth_next[WIDTH]}};
                        rdy_d    = 1'b1;
                        state_d  = DONE;
                    end
                end
                DIV: begin
                    if (opnd_q == '0) begin
                        result_d = '0;
                        exc_d    = 1'b1;
                        rdy_d    = 1'b1;
                        state_d  = DONE;
                    end else begin
                        cnt_clr = 1'b0;
                        cnt_en  = 1'b1;
                        work_d  = div_next;
                        if (cnt_tc) begin
                            result_d = neg_q ? (~quo + 1'b1) : quo;
                            exc_d    = ovf_q;
                            rdy_d    = 1'b1;
                            state_d  = DONE;
                        end
                    end
                end
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            work_q   <= '0;
            opnd_q   <= '0;
            neg_q    <= 1'b0;
            ovf_q    <= 1'b0;
            result_q <= '0;
            exc_q    <= 1'b0;
            rdy_q    <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            work_q   <= work_d;
            opnd_q   <= opnd_d;
            neg_q    <= neg_d;
            ovf_q    <= ovf_d;
            result_q <= result_d;
            exc_q    <= exc_d;
            rdy_q    <= rdy_d;
            busy_q   <= busy_d;
        end
    end

    assign data_result    = result_q;
    assign data_exception = exc_q;
    assign data_resultRDY = rdy_q;
    assign busy           = busy_q;

endmodule

// File: tb/tb_multdiv.sv
// Scoreboard bench for multdiv: stimulus pushes expected result, exception
// and completion cycle; a negedge monitor pops on every RDY strobe.
module tb_multdiv;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] data_operandA = '0;
    logic [31:0] data_operandB = '0;
    logic        ctrl_MULT = 1'b0;
    logic        ctrl_DIV  = 1'b0;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;
    logic        busy;

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;

    typedef struct {
        logic [31:0] res;
        logic        exc;
        int          at;
        string       name;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    multdiv dut (
        .clock          (clock),
        .reset          (reset),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .ctrl_MULT      (ctrl_MULT),
        .ctrl_DIV       (ctrl_DIV),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY),
        .busy           (busy)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    // Monitor: every strobe must match the oldest outstanding expectation.
    always @(negedge clock) begin
        if (reset === 1'b1 && data_resultRDY === 1'b1) begin
            if (sb_q.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL unexpected_rdy: strobe at cycle %0d, expected none (result %h)",
                         cyc, data_result);
            end else begin
                mon_e = sb_q.pop_front();
                $display("txn %s: result=%h exc=%b cycle=%0d (exp %h %b %0d)",
                         mon_e.name, data_result, data_exception, cyc,
                         mon_e.res, mon_e.exc, mon_e.at);
                check({mon_e.name, "_result"}, data_result, mon_e.res);
                check({mon_e.name, "_exc"}, {31'b0, data_exception}, {31'b0, mon_e.exc});
                check({mon_e.name, "_cycle"}, cyc, mon_e.at);
            end
        end
    end

    task automatic issue(input string name, input logic m, input logic d,
                         input logic [31:0] a, input logic [31:0] b,
                         input bit push, input logic [31:0] r, input logic e, input int lat);
        @(negedge clock);
        if (push) sb_q.push_back('{res: r, exc: e, at: cyc + 1 + lat, name: name});
        ctrl_MULT     = m;
        ctrl_DIV      = d;
        data_operandA = a;
        data_operandB = b;
        @(negedge clock);
        ctrl_MULT = 1'b0;
        ctrl_DIV  = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (sb_q.size() != 0 && n < 100) begin
            @(negedge clock);
            #1;
            n++;
        end
        compared++;
        if (sb_q.size() != 0) begin
            mismatched++;
            $display("FAIL %s_timeout: %0d results outstanding, expected 0", name, sb_q.size());
            sb_q.delete();
        end
        @(negedge clock);
        check({name, "_busy_after"}, {31'b0, busy}, 32'd0);
    endtask

    initial begin
        #2 reset = 1'b0;
        #1;
        check("reset_result", data_result, 32'd0);
        check("reset_exc", {31'b0, data_exception}, 32'd0);
        check("reset_rdy", {31'b0, data_resultRDY}, 32'd0);
        check("reset_busy", {31'b0, busy}, 32'd0);
        // Start pulses during reset are ignored.
        @(negedge clock);
        ctrl_MULT = 1'b1;
        data_operandA = 32'd5;
        data_operandB = 32'd5;
        @(negedge clock);
        ctrl_MULT = 1'b0;
        check("reset_ignore_busy", {31'b0, busy}, 32'd0);
        @(negedge clock);
        reset = 1'b1;

        issue("mul_7_m3", 1, 0, 32'd7, 32'hFFFFFFFD, 1, 32'hFFFFFFEB, 0, 32);
        #1 check("mul_busy_mid", {31'b0, busy}, 32'd1);
        wait_done("mul_7_m3");

        issue("mul_ovf", 1, 0, 32'h00010000, 32'h00010000, 1, 32'h00000000, 1, 32);
        wait_done("mul_ovf");

        issue("mul_m6_m7", 1, 0, 32'hFFFFFFFA, 32'hFFFFFFF9, 1, 32'd42, 0, 32);
        wait_done("mul_m6_m7");

        issue("both_6_3", 1, 1, 32'd6, 32'd3, 1, 32'd18, 0, 32);
        wait_done("both_6_3");

        issue("div_m17_5", 0, 1, 32'hFFFFFFEF, 32'd5, 1, 32'hFFFFFFFD, 0, 32);
        wait_done("div_m17_5");

        issue("div_100_m7", 0, 1, 32'd100, 32'hFFFFFFF9, 1, 32'hFFFFFFF2, 0, 32);
        wait_done("div_100_m7");

        issue("div_by_zero", 0, 1, 32'd9, 32'd0, 1, 32'd0, 1, 1);
        wait_done("div_by_zero");

        issue("div_ovf", 0, 1, 32'h80000000, 32'hFFFFFFFF, 1, 32'h80000000, 1, 32);
        wait_done("div_ovf");

        // A new start ten cycles in abandons the multiply.
        issue("mul_abandon", 1, 0, 32'd3, 32'd4, 0, 32'd0, 0, 0);
        repeat (8) @(negedge clock);
        issue("div_20_4", 0, 1, 32'd20, 32'd4, 1, 32'd5, 0, 32);
        wait_done("div_20_4");

        // Reset at iteration 15 of a multiply.
        issue("mul_reset", 1, 0, 32'd5, 32'd5, 0, 32'd0, 0, 0);
        repeat (15) @(negedge clock);
        reset = 1'b0;
        #1;
        check("midreset_result", data_result, 32'd0);
        check("midreset_exc", {31'b0, data_exception}, 32'd0);
        check("midreset_rdy", {31'b0, data_resultRDY}, 32'd0);
        check("midreset_busy", {31'b0, busy}, 32'd0);
        @(negedge clock);
        reset = 1'b1;
        repeat (40) @(negedge clock);

        issue("mul_2_2", 1, 0, 32'd2, 32'd2, 1, 32'd4, 0, 32);
        wait_done("mul_2_2");

        repeat (5) @(negedge clock);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
